// File: rtl/sw_debounce_pkg.sv
// Board-wide constants and shared types for the slide-switch debouncer.
// The default debounce length is derived from the 5 MHz clock-wizard output.
package sw_debounce_pkg;

  localparam int CLK_5MHZ_HZ = 5_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int N_SW_BOARD  = 4;

  // Clock cycles spanning a debounce window of the given length in milliseconds.
  function automatic int db_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  localparam int DB_CNT_DEFAULT = db_cycles(CLK_5MHZ_HZ, DEBOUNCE_MS);
  localparam int CNT_W_DEFAULT  = 16;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_RISE = 2'd1,
    KIND_FALL = 2'd2
  } edge_kind_t;

endpackage

// File: rtl/sw_debounce_if.sv
// Switch bundle between the board pins and the debouncer's consumers.
// The master side drives raw levels; the slave side returns clean levels and strobes.
interface sw_debounce_if
  import sw_debounce_pkg::*;
#(
  parameter int N_SW = N_SW_BOARD
);

  logic [N_SW-1:0] sw;
  logic [N_SW-1:0] sw_db;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;
  logic            sw_chg;

  modport master (
    output sw,
    input  sw_db,
    input  sw_rise,
    input  sw_fall,
    input  sw_chg
  );

  modport slave (
    input  sw,
    output sw_db,
    output sw_rise,
    output sw_fall,
    output sw_chg
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch lane: 2-FF synchroniser, stability counter, accepted level and edge strobes.
// accept is a registers-only look-ahead so the top can register sw_chg alongside the strobes.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int DB_CNT = DB_CNT_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sw,
  output logic sw_db,
  output logic sw_rise,
  output logic sw_fall,
  output logic accept
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             db_reg;
  logic             db_next;
  logic             rise_reg;
  logic             fall_reg;
  edge_kind_t       kind_next;

  // Any sample matching the held level restarts the count, so only an
  // unbroken run of DB_CNT differing samples moves the output.
  always_comb begin
    cnt_next  = cnt_reg;
    db_next   = db_reg;
    kind_next = KIND_NONE;
    if (sync2_reg == db_reg) begin
      cnt_next = '0;
    end else if (cnt_reg != CNT_LAST) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end else begin
      cnt_next  = '0;
      db_next   = sync2_reg;
      kind_next = sync2_reg ? KIND_RISE : KIND_FALL;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      cnt_reg   <= '0;
      db_reg    <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      sync1_reg <= sw;
      sync2_reg <= sync1_reg;
      cnt_reg   <= cnt_next;
      db_reg    <= db_next;
      rise_reg  <= (kind_next == KIND_RISE);
      fall_reg  <= (kind_next == KIND_FALL);
    end
  end

  assign sw_db   = db_reg;
  assign sw_rise = rise_reg;
  assign sw_fall = fall_reg;
  assign accept  = (kind_next != KIND_NONE);

endmodule

// File: rtl/sw_debounce.sv
// Debounces the board slide switches: one independent lane per switch plus a
// shared change strobe so downstream logic restarts once per real switch move.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int N_SW   = N_SW_BOARD,
  parameter int DB_CNT = DB_CNT_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input logic          clk_in,
  input logic          rst,
  sw_debounce_if.slave sw_bus
);

  logic [N_SW-1:0] db_w;
  logic [N_SW-1:0] rise_w;
  logic [N_SW-1:0] fall_w;
  logic [N_SW-1:0] accept_w;
  logic            chg_reg;

  generate
    for (genvar gi = 0; gi < N_SW; gi++) begin : g_lane
      sw_debounce_bit #(
        .DB_CNT (DB_CNT),
        .CNT_W  (CNT_W)
      ) u_bit (
        .clk_in  (clk_in),
        .rst     (rst),
        .sw      (sw_bus.sw[gi]),
        .sw_db   (db_w[gi]),
        .sw_rise (rise_w[gi]),
        .sw_fall (fall_w[gi]),
        .accept  (accept_w[gi])
      );
    end
  endgenerate

  // Registered from the lanes' look-ahead so it lines up with their strobes.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      chg_reg <= 1'b0;
    end else begin
      chg_reg <= |accept_w;
    end
  end

  assign sw_bus.sw_db   = db_w;
  assign sw_bus.sw_rise = rise_w;
  assign sw_bus.sw_fall = fall_w;
  assign sw_bus.sw_chg  = chg_reg;

endmodule
